// File: rtl/gemm_pkg.sv
// Shared types and helpers for the GEMM lane sequencer.
package gemm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } gemm_state_e;

    function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
        ceil_div = (num + den - 32'd1) / den;
    endfunction

endpackage

// File: rtl/gemm_mac_lane.sv
// One output column: extend, multiply and accumulate a single A x B_l product per cycle.
module gemm_mac_lane #(
    parameter int unsigned DataWidthA = 8,
    parameter int unsigned DataWidthB = 8,
    parameter int unsigned DataWidthC = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  k_first_i,
    input  logic                  signed_i,
    input  logic [DataWidthA-1:0] a_i,
    input  logic [DataWidthB-1:0] b_i,
    output logic [DataWidthC-1:0] sum_o
);

    logic [DataWidthC-1:0] a_ext_s;
    logic [DataWidthC-1:0] b_ext_s;
    logic [DataWidthC-1:0] prod_s;
    logic [DataWidthC-1:0] acc_d;
    logic [DataWidthC-1:0] acc_q;

    // Truncated product of the extended operands is the exact result modulo 2^DataWidthC.
    always_comb begin
        if (signed_i) begin
            a_ext_s = {{(DataWidthC-DataWidthA){a_i[DataWidthA-1]}}, a_i};
            b_ext_s = {{(DataWidthC-DataWidthB){b_i[DataWidthB-1]}}, b_i};
        end else begin
            a_ext_s = {{(DataWidthC-DataWidthA){1'b0}}, a_i};
            b_ext_s = {{(DataWidthC-DataWidthB){1'b0}}, b_i};
        end
        prod_s = a_ext_s * b_ext_s;
        if (k_first_i) begin
            sum_o = prod_s;
        end else begin
            sum_o = acc_q + prod_s;
        end
        if (en_i) begin
            acc_d = sum_o;
        end else begin
            acc_d = acc_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= {DataWidthC{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/gemm_lane_sequencer.sv
// Output-stationary GEMM sequencer: walks m/t/k, drives A/B/C SRAMs and NumLanes MAC lanes.
module gemm_lane_sequencer
    import gemm_pkg::*;
#(
    parameter int unsigned DataWidthA     = 8,
    parameter int unsigned DataWidthB     = 8,
    parameter int unsigned DataWidthC     = 32,
    parameter int unsigned NumLanes       = 4,
    parameter int unsigned SizeWidth      = 12,
    parameter int unsigned SRAMAddrWidthA = 12,
    parameter int unsigned SRAMAddrWidthB = 12,
    parameter int unsigned SRAMAddrWidthC = 12
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           signed_i,
    input  logic [SizeWidth-1:0]           M_size_i,
    input  logic [SizeWidth-1:0]           K_size_i,
    input  logic [SizeWidth-1:0]           N_size_i,
    output logic [SRAMAddrWidthA-1:0]      sram_a_addr_o,
    input  logic [DataWidthA-1:0]          sram_a_rdata_i,
    output logic [SRAMAddrWidthB-1:0]      sram_b_addr_o,
    input  logic [NumLanes*DataWidthB-1:0] sram_b_rdata_i,
    output logic [SRAMAddrWidthC-1:0]      sram_c_addr_o,
    output logic [NumLanes*DataWidthC-1:0] sram_c_wdata_o,
    output logic                           sram_c_we_o,
    output logic [NumLanes-1:0]            sram_c_lane_en_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [31:0]                    perf_cycles_o
);

    localparam logic [SizeWidth-1:0] SizeZero = {SizeWidth{1'b0}};
    localparam logic [SizeWidth-1:0] SizeOne  = {{(SizeWidth-1){1'b0}}, 1'b1};
    localparam logic [SizeWidth:0]   ColStep  = (SizeWidth+1)'(NumLanes);

    gemm_state_e state_q, state_d;
    logic                      signed_q, signed_d;
    logic [SizeWidth-1:0]      m_size_q, m_size_d, k_size_q, k_size_d, n_size_q, n_size_d;
    logic [SizeWidth-1:0]      nt_q, nt_d;
    logic [SizeWidth-1:0]      m_q, m_d, t_q, t_d, k_q, k_d;
    logic [SRAMAddrWidthA-1:0] a_addr_q, a_addr_d, a_row_q, a_row_d;
    logic [SRAMAddrWidthB-1:0] b_addr_q, b_addr_d, b_tile_q, b_tile_d;
    logic [SRAMAddrWidthC-1:0] c_addr_q, c_addr_d;
    logic [SizeWidth:0]        col_iss_q, col_iss_d, col_q, col_d;
    logic                      vld_q, vld_d, first_q, first_d, last_q, last_d;
    logic [31:0]               perf_q, perf_d;
    logic [DataWidthC-1:0]     lane_sum_s [NumLanes];
    logic [NumLanes-1:0]       lane_en_s;
    logic [NumLanes*DataWidthC-1:0] wdata_s;

    assign busy_o           = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done_o           = (state_q == ST_DONE);
    assign sram_c_we_o      = vld_q & last_q;
    assign sram_a_addr_o    = a_addr_q;
    assign sram_b_addr_o    = b_addr_q;
    assign sram_c_addr_o    = c_addr_q;
    assign sram_c_lane_en_o = lane_en_s;
    assign sram_c_wdata_o   = wdata_s;
    assign perf_cycles_o    = perf_q;

    // Next-state: FSM, loop counters and incremental addresses; the issue stage is delayed
    // one cycle (vld/first/last/col) to line up with the SRAM read latency.
    always_comb begin
        state_d   = state_q;
        signed_d  = signed_q;
        m_size_d  = m_size_q;
        k_size_d  = k_size_q;
        n_size_d  = n_size_q;
        nt_d      = nt_q;
        m_d       = m_q;
        t_d       = t_q;
        k_d       = k_q;
        a_addr_d  = a_addr_q;
        a_row_d   = a_row_q;
        b_addr_d  = b_addr_q;
        b_tile_d  = b_tile_q;
        col_iss_d = col_iss_q;
        col_d     = col_q;
        vld_d     = 1'b0;
        first_d   = first_q;
        last_d    = last_q;
        if (sram_c_we_o) begin
            c_addr_d = c_addr_q + SRAMAddrWidthC'(1);
        end else begin
            c_addr_d = c_addr_q;
        end
        if (busy_o) begin
            perf_d = perf_q + 32'd1;
        end else begin
            perf_d = perf_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    signed_d  = signed_i;
                    m_size_d  = M_size_i;
                    k_size_d  = K_size_i;
                    n_size_d  = N_size_i;
                    nt_d      = SizeWidth'(ceil_div(32'(N_size_i), 32'(NumLanes)));
                    m_d       = SizeZero;
                    t_d       = SizeZero;
                    k_d       = SizeZero;
                    a_addr_d  = {SRAMAddrWidthA{1'b0}};
                    a_row_d   = {SRAMAddrWidthA{1'b0}};
                    b_addr_d  = {SRAMAddrWidthB{1'b0}};
                    b_tile_d  = {SRAMAddrWidthB{1'b0}};
                    c_addr_d  = {SRAMAddrWidthC{1'b0}};
                    col_iss_d = {(SizeWidth+1){1'b0}};
                    perf_d    = 32'd0;
                    if ((M_size_i == SizeZero) || (K_size_i == SizeZero) || (N_size_i == SizeZero)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                vld_d   = 1'b1;
                first_d = (k_q == SizeZero);
                last_d  = (k_q == k_size_q - SizeOne);
                col_d   = col_iss_q;
                if (k_q != k_size_q - SizeOne) begin
                    k_d      = k_q + SizeOne;
                    a_addr_d = a_addr_q + SRAMAddrWidthA'(1);
                    b_addr_d = b_addr_q + SRAMAddrWidthB'(nt_q);
                end else if (t_q != nt_q - SizeOne) begin
                    k_d       = SizeZero;
                    t_d       = t_q + SizeOne;
                    a_addr_d  = a_row_q;
                    b_tile_d  = b_tile_q + SRAMAddrWidthB'(1);
                    b_addr_d  = b_tile_q + SRAMAddrWidthB'(1);
                    col_iss_d = col_iss_q + ColStep;
                end else if (m_q != m_size_q - SizeOne) begin
                    k_d       = SizeZero;
                    t_d       = SizeZero;
                    m_d       = m_q + SizeOne;
                    a_row_d   = a_row_q + SRAMAddrWidthA'(k_size_q);
                    a_addr_d  = a_row_q + SRAMAddrWidthA'(k_size_q);
                    b_tile_d  = {SRAMAddrWidthB{1'b0}};
                    b_addr_d  = {SRAMAddrWidthB{1'b0}};
                    col_iss_d = {(SizeWidth+1){1'b0}};
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and pipeline registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            signed_q  <= 1'b0;
            m_size_q  <= SizeZero;
            k_size_q  <= SizeZero;
            n_size_q  <= SizeZero;
            nt_q      <= SizeZero;
            m_q       <= SizeZero;
            t_q       <= SizeZero;
            k_q       <= SizeZero;
            a_addr_q  <= {SRAMAddrWidthA{1'b0}};
            a_row_q   <= {SRAMAddrWidthA{1'b0}};
            b_addr_q  <= {SRAMAddrWidthB{1'b0}};
            b_tile_q  <= {SRAMAddrWidthB{1'b0}};
            c_addr_q  <= {SRAMAddrWidthC{1'b0}};
            col_iss_q <= {(SizeWidth+1){1'b0}};
            col_q     <= {(SizeWidth+1){1'b0}};
            vld_q     <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            perf_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            signed_q  <= signed_d;
            m_size_q  <= m_size_d;
            k_size_q  <= k_size_d;
            n_size_q  <= n_size_d;
            nt_q      <= nt_d;
            m_q       <= m_d;
            t_q       <= t_d;
            k_q       <= k_d;
            a_addr_q  <= a_addr_d;
            a_row_q   <= a_row_d;
            b_addr_q  <= b_addr_d;
            b_tile_q  <= b_tile_d;
            c_addr_q  <= c_addr_d;
            col_iss_q <= col_iss_d;
            col_q     <= col_d;
            vld_q     <= vld_d;
            first_q   <= first_d;
            last_q    <= last_d;
            perf_q    <= perf_d;
        end
    end

    for (genvar l = 0; l < NumLanes; l++) begin : g_lane
        gemm_mac_lane #(
            .DataWidthA(DataWidthA),
            .DataWidthB(DataWidthB),
            .DataWidthC(DataWidthC)
        ) u_lane (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .en_i     (vld_q),
            .k_first_i(first_q),
            .signed_i (signed_q),
            .a_i      (sram_a_rdata_i),
            .b_i      (sram_b_rdata_i[l*DataWidthB +: DataWidthB]),
            .sum_o    (lane_sum_s[l])
        );
    end

    // Write masking: lanes past column N-1 of the last tile stay silent.
    always_comb begin
        lane_en_s = {NumLanes{1'b0}};
        wdata_s   = {(NumLanes*DataWidthC){1'b0}};
        for (int l = 0; l < NumLanes; l++) begin
            if (sram_c_we_o && ((32'(col_q) + 32'(l)) < 32'(n_size_q))) begin
                lane_en_s[l]                   = 1'b1;
                wdata_s[l*DataWidthC +: DataWidthC] = lane_sum_s[l];
            end else begin
                lane_en_s[l] = 1'b0;
            end
        end
    end

endmodule

// File: doc/gemm_lane_sequencer.md
# gemm_lane_sequencer

Parametrised GEMM engine computing C[M×N] = A[M×K] · B[K×N] with NumLanes output columns computed in parallel per cycle. It sits under the GEMM accelerator top, drives the A, B and C SRAM ports directly, and supports run-time signed/unsigned operand mode. Tiles are output-stationary with fully pipelined back-to-back K loops, and the block reports a cycle counter. B and C SRAMs are NumLanes elements wide; the A SRAM is one element wide.

## Interface
- DataWidthA, 8: A element width
- DataWidthB, 8: B element width
- DataWidthC, 32: C element / accumulator width
- NumLanes, 4: parallel output columns (P), ≥1
- SizeWidth, 12: width of M/K/N size inputs
- SRAMAddrWidthA / B / C, 12: SRAM word address widths
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  start request, sampled only in IDLE
- signed_i  in  1  1 = two's-complement operands, 0 = unsigned; latched at start
- M_size_i, K_size_i, N_size_i  in  SizeWidth  matrix sizes; latched at start
- sram_a_addr_o  out  SRAMAddrWidthA  A word address
- sram_a_rdata_i  in  DataWidthA  A data, 1-cycle read latency
- sram_b_addr_o  out  SRAMAddrWidthB  B word address
- sram_b_rdata_i  in  NumLanes*DataWidthB  B data, lane l at bits [l*DataWidthB +: DataWidthB], 1-cycle latency
- sram_c_addr_o  out  SRAMAddrWidthC  C word address
- sram_c_wdata_o  out  NumLanes*DataWidthC  C write data
- sram_c_we_o  out  1  C write strobe
- sram_c_lane_en_o  out  NumLanes  per-lane write enable
- busy_o  out  1  operation in progress
- done_o  out  1  single-cycle completion pulse
- perf_cycles_o  out  32  cycles of last operation

## Operation
- NT = ceil(N/P). Memory layout: A row-major, addr m·K+k; B word k·NT+t holds columns t·P…t·P+P−1; C word m·NT+t likewise.
- Loop order: m outer, t middle, k inner. Addresses come from incremental registers (A row base += K, B += NT per k, C += 1 per tile); no multipliers.
- FSM: IDLE → (start_i, all sizes ≠0) RUN; IDLE → (start_i, any size 0) DONE; RUN → DRAIN after issuing final (m,t,k); DRAIN → DONE; DONE → IDLE.
- Per lane: product = A × B_l, sign- (signed_i=1) or zero-extended to DataWidthC; accumulation wraps modulo 2^DataWidthC. At k=0, acc = product; otherwise acc = acc + product.
- Last-tile masking: lane l of tile t enabled iff t·P+l < N. Disabled lanes drive wdata 0 and lane_en 0.
- start_i outside IDLE is ignored. Size and mode inputs are don't-care except at the start cycle.
- rst_i mid-operation: immediate return to IDLE, all outputs at reset values, no further writes.

## Timing
- Reset values: every output 0, including addresses.
- Start sampled at edge 0. RUN occupies cycles 1…M·NT·K and issues one (A,B) address pair per cycle, registered.
- Read data for the address issued in cycle c is consumed in cycle c+1.
- C write for a tile is presented combinationally (acc + last product) in the cycle after its last k issue, with sram_c_we_o=1 for exactly one cycle.
- Tiles run back-to-back with no bubble. The final write occurs in cycle M·NT·K+1 (DRAIN).
- done_o=1 in cycle M·NT·K+2 only.
- busy_o=1 in RUN and DRAIN.
- perf_cycles_o counts cycles with busy_o=1 and holds its value until the next start; 0 for zero-size runs.
- Zero-size start: done_o in cycle 1, no writes.

## Structure
- gemm_pkg: state enum (IDLE, RUN, DRAIN, DONE), ceil_div function for NT.
- Sub-module gemm_mac_lane: one lane's extend/multiply/accumulate with k_first and signed controls; instantiated NumLanes times via generate.
- Top holds the FSM, loop counters, address incrementers, lane mask and perf counter.

## Test plan
- M=2,K=3,N=5,P=4, unsigned, A=1…6, B=1…15 → 4 C writes (addr 0…3); lane_en 1111,0001,1111,0001; results match golden model; done_o at cycle 2·2·3+2=14.
- Signed, K=1, A=−128, B=−128 all lanes → every enabled C value = 16384. Same operands unsigned → 128·128 = 16384; A=0xFF, B=0x02 → unsigned 510, signed −2.
- Start with N=0 → done_o in cycle 1, sram_c_we_o never asserted, perf_cycles_o=0.
- start_i pulsed again during RUN, with different sizes → ignored; results and cycle count identical to a single start.
- rst_i asserted mid-RUN → outputs 0 same cycle, no further writes; a subsequent start completes correctly.
- Random 32×32×32 sweep, both modes, P∈{1,3,4} → bit-exact against golden model; perf_cycles_o = M·NT·K+1.
